// File: rtl/uart_rx_frame.sv
// uart_rx_frame -- parametrised UART receiver.
//   Data width, parity and stop-bit count are parameters; each bit is the 3-sample
//   majority around mid-bit. Line errors are reported as single-cycle pulses per
//   frame, and good frames land in a ready/valid output register.
//   Optional macro UART_RX_BREAK_DETECT_EN adds o_Break: an all-zero frame is
//   reported as a break instead of a framing error.
module uart_rx_frame #(
  parameter int SYS_CLOCK     = 50000000,
  parameter int UART_BAUDRATE = 115200,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic                 i_SysClock,
  input  logic                 i_ResetN,
  input  logic                 i_RxSerial,
  output logic [DATA_BITS-1:0] o_RxByte,
  output logic                 o_RxValid,
  input  logic                 i_RxReady,
  output logic                 o_RxDone,
  output logic                 o_ParityErr,
  output logic                 o_FrameErr,
  output logic                 o_Overrun
`ifdef UART_RX_BREAK_DETECT_EN
  ,
  output logic                 o_Break
`endif
);

  localparam int unsigned CLKS_PER_BIT = SYS_CLOCK / UART_BAUDRATE;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF         = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_SA   = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] C_SB   = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] C_SC   = CNT_W'(HALF + 1);

  localparam logic [3:0] C_DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] C_STOP_LAST = 4'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  logic                 r_RxMeta;
  logic                 r_RxSync;
  logic [1:0]           r_SyncPrimed;
  logic                 r_Armed;
  logic [2:0]           r_State;
  logic [CNT_W-1:0]     r_ClkCnt;
  logic [3:0]           r_BitIdx;
  logic [1:0]           r_Samp;
  logic [DATA_BITS-1:0] r_Shift;
  logic                 r_ParAcc;
  logic                 r_ParBit;
  logic                 r_StopOk;

  logic w_Rx;
  logic w_StartDetect;
  logic w_SampA;
  logic w_SampB;
  logic w_SampC;
  logic w_Vote;
  logic w_Complete;
  logic w_StopOkFinal;
  logic w_ParityOk;
  logic w_FrameBad;
  logic w_ParBad;
  logic w_Good;
  logic w_Deliver;
  logic w_Break;

  assign w_Rx          = r_RxSync;
  assign w_StartDetect = (r_State == S_IDLE) && r_Armed && !w_Rx;
  assign w_SampA       = (r_ClkCnt == C_SA);
  assign w_SampB       = (r_ClkCnt == C_SB);
  assign w_SampC       = (r_ClkCnt == C_SC);
  assign w_Vote        = (r_Samp[0] & r_Samp[1]) | (r_Samp[0] & w_Rx) | (r_Samp[1] & w_Rx);

  // Completion is evaluated on the third sample of the last stop bit, so the
  // result pulses appear one clock after that sample.
  assign w_Complete    = (r_State == S_STOP) && w_SampC && (r_BitIdx == C_STOP_LAST);
  assign w_StopOkFinal = r_StopOk & w_Vote;
  assign w_ParityOk    = (PARITY == 1) ? (r_ParAcc ^ r_ParBit) : ~(r_ParAcc ^ r_ParBit);
  assign w_FrameBad    = w_Complete && !w_StopOkFinal;
  assign w_ParBad      = w_Complete && w_StopOkFinal && (PARITY != 0) && !w_ParityOk;
  assign w_Good        = w_Complete && w_StopOkFinal && !w_ParBad;
  assign w_Deliver     = w_Good && (!o_RxValid || i_RxReady);

  // Two-flop synchroniser; the primed flag marks when the synced line carries real data
  always_ff @(posedge i_SysClock or negedge i_ResetN) begin
    if (!i_ResetN) begin
      r_RxMeta     <= 1'b1;
      r_RxSync     <= 1'b1;
      r_SyncPrimed <= 2'b00;
    end else begin
      r_RxMeta     <= i_RxSerial;
      r_RxSync     <= r_RxMeta;
      r_SyncPrimed <= {r_SyncPrimed[0], 1'b1};
    end
  end

  // Receive FSM with bit-period counter, sample capture and frame datapath
  always_ff @(posedge i_SysClock or negedge i_ResetN) begin
    if (!i_ResetN) begin
      r_Armed  <= 1'b0;
      r_State  <= S_IDLE;
      r_ClkCnt <= '0;
      r_BitIdx <= '0;
      r_Samp   <= '0;
      r_Shift  <= '0;
      r_ParAcc <= 1'b0;
      r_ParBit <= 1'b0;
      r_StopOk <= 1'b1;
    end else begin
      // A start is accepted only after a genuine high level has been seen
      if (r_SyncPrimed[1] && w_Rx) begin
        r_Armed <= 1'b1;
      end

      if (r_State != S_IDLE && r_State != S_WAIT_IDLE) begin
        r_ClkCnt <= (r_ClkCnt == C_LAST) ? '0 : r_ClkCnt + CNT_W'(1);
        if (w_SampA) begin
          r_Samp[0] <= w_Rx;
        end
        if (w_SampB) begin
          r_Samp[1] <= w_Rx;
        end
      end

      case (r_State)
        S_IDLE: begin
          r_ClkCnt <= '0;
          if (w_StartDetect) begin
            // The detection cycle is count 0 of the start bit
            r_State  <= S_START;
            r_ClkCnt <= CNT_W'(1);
            r_Armed  <= 1'b0;
            r_BitIdx <= '0;
            r_ParAcc <= 1'b0;
            r_ParBit <= 1'b0;
            r_StopOk <= 1'b1;
          end
        end
        S_START: begin
          if (w_SampC) begin
            if (!w_Vote) begin
              r_State <= S_DATA;
            end else begin
              r_State  <= S_IDLE;
              r_ClkCnt <= '0;
            end
          end
        end
        S_DATA: begin
          if (w_SampC) begin
            r_Shift  <= {w_Vote, r_Shift[DATA_BITS-1:1]};
            r_ParAcc <= r_ParAcc ^ w_Vote;
            if (r_BitIdx == C_DATA_LAST) begin
              r_BitIdx <= '0;
              r_State  <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              r_BitIdx <= r_BitIdx + 4'd1;
            end
          end
        end
        S_PARITY: begin
          if (w_SampC) begin
            r_ParBit <= w_Vote;
            r_State  <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_SampC) begin
            if (r_BitIdx == C_STOP_LAST) begin
              // Leave at mid-bit so a back-to-back start edge is not missed
              r_State  <= w_StopOkFinal ? S_IDLE : S_WAIT_IDLE;
              r_ClkCnt <= '0;
              r_BitIdx <= '0;
            end else begin
              r_StopOk <= w_StopOkFinal;
              r_BitIdx <= r_BitIdx + 4'd1;
            end
          end
        end
        S_WAIT_IDLE: begin
          if (w_Rx) begin
            r_State <= S_IDLE;
          end
        end
        default: begin
          r_State  <= S_IDLE;
          r_ClkCnt <= '0;
        end
      endcase
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  logic r_AnyOne;

  assign w_Break = w_FrameBad && !(r_AnyOne | w_Vote);

  // Track whether any data, parity or stop sample of the frame was 1
  always_ff @(posedge i_SysClock or negedge i_ResetN) begin
    if (!i_ResetN) begin
      r_AnyOne <= 1'b0;
      o_Break  <= 1'b0;
    end else begin
      o_Break <= w_Break;
      if (w_StartDetect) begin
        r_AnyOne <= 1'b0;
      end else if (w_SampC && w_Vote &&
                   (r_State == S_DATA || r_State == S_PARITY || r_State == S_STOP)) begin
        r_AnyOne <= 1'b1;
      end
    end
  end
`else
  assign w_Break = 1'b0;
`endif

  // Output register, handshake and per-frame result pulses
  always_ff @(posedge i_SysClock or negedge i_ResetN) begin
    if (!i_ResetN) begin
      o_RxByte    <= '0;
      o_RxValid   <= 1'b0;
      o_RxDone    <= 1'b0;
      o_ParityErr <= 1'b0;
      o_FrameErr  <= 1'b0;
      o_Overrun   <= 1'b0;
    end else begin
      o_RxDone    <= w_Deliver;
      o_Overrun   <= w_Good && o_RxValid && !i_RxReady;
      o_ParityErr <= w_ParBad;
      o_FrameErr  <= w_FrameBad && !w_Break;
      if (w_Deliver) begin
        o_RxByte  <= r_Shift;
        o_RxValid <= 1'b1;
      end else if (i_RxReady) begin
        o_RxValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: three instances (8N1, 8E1, 5O2) on a shared
// clock/reset, each with its own serial line and expected-event queue.
module tb_uart_rx_frame;

  localparam int SYS  = 1600;
  localparam int BAUD = 100;
  localparam int CPB  = SYS / BAUD;

  localparam int EV_DONE = 1;
  localparam int EV_PERR = 2;
  localparam int EV_FERR = 3;
  localparam int EV_OVR  = 4;
  localparam int EV_BRK  = 5;

  typedef struct {
    int kind;
    int data;
  } ev_t;

  logic clk;
  logic rst_n;
  logic r_Line  [3];
  logic r_Ready [3];

  logic [7:0] d0_byte, d1_byte;
  logic [4:0] d2_byte;
  logic d0_valid, d0_done, d0_perr, d0_ferr, d0_ovr;
  logic d1_valid, d1_done, d1_perr, d1_ferr, d1_ovr;
  logic d2_valid, d2_done, d2_perr, d2_ferr, d2_ovr;
  logic d0_brk, d1_brk, d2_brk;

  ev_t q0[$];
  ev_t q1[$];
  ev_t q2[$];

  int n_vec;
  int n_err;

  uart_rx_frame #(.SYS_CLOCK(SYS), .UART_BAUDRATE(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .i_SysClock(clk), .i_ResetN(rst_n), .i_RxSerial(r_Line[0]),
    .o_RxByte(d0_byte), .o_RxValid(d0_valid), .i_RxReady(r_Ready[0]),
    .o_RxDone(d0_done), .o_ParityErr(d0_perr), .o_FrameErr(d0_ferr), .o_Overrun(d0_ovr)
`ifdef UART_RX_BREAK_DETECT_EN
    , .o_Break(d0_brk)
`endif
  );

  uart_rx_frame #(.SYS_CLOCK(SYS), .UART_BAUDRATE(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut1 (
    .i_SysClock(clk), .i_ResetN(rst_n), .i_RxSerial(r_Line[1]),
    .o_RxByte(d1_byte), .o_RxValid(d1_valid), .i_RxReady(r_Ready[1]),
    .o_RxDone(d1_done), .o_ParityErr(d1_perr), .o_FrameErr(d1_ferr), .o_Overrun(d1_ovr)
`ifdef UART_RX_BREAK_DETECT_EN
    , .o_Break(d1_brk)
`endif
  );

  uart_rx_frame #(.SYS_CLOCK(SYS), .UART_BAUDRATE(BAUD), .DATA_BITS(5), .PARITY(1), .STOP_BITS(2)) u_dut2 (
    .i_SysClock(clk), .i_ResetN(rst_n), .i_RxSerial(r_Line[2]),
    .o_RxByte(d2_byte), .o_RxValid(d2_valid), .i_RxReady(r_Ready[2]),
    .o_RxDone(d2_done), .o_ParityErr(d2_perr), .o_FrameErr(d2_ferr), .o_Overrun(d2_ovr)
`ifdef UART_RX_BREAK_DETECT_EN
    , .o_Break(d2_brk)
`endif
  );

`ifndef UART_RX_BREAK_DETECT_EN
  assign d0_brk = 1'b0;
  assign d1_brk = 1'b0;
  assign d2_brk = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int kind_of(input logic done, input logic perr, input logic ferr,
                                 input logic ovr, input logic brk);
    int n;
    n = int'(done) + int'(perr) + int'(ferr) + int'(ovr) + int'(brk);
    if (n > 1) return 9;
    if (done) return EV_DONE;
    if (perr) return EV_PERR;
    if (ferr) return EV_FERR;
    if (ovr)  return EV_OVR;
    if (brk)  return EV_BRK;
    return 0;
  endfunction

  function automatic ev_t mk(input int kind, input int data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    return e;
  endfunction

  always @(negedge clk) begin : mon0
    ev_t e;
    int k;
    k = kind_of(d0_done, d0_perr, d0_ferr, d0_ovr, d0_brk);
    if (k != 0) begin
      if (q0.size() == 0) chk_eq("d0_spurious", k, 0);
      else begin
        e = q0.pop_front();
        chk_eq("d0_event", k, e.kind);
        if (k == EV_DONE && e.kind == EV_DONE) chk_eq("d0_byte", int'(d0_byte), e.data);
      end
    end
  end

  always @(negedge clk) begin : mon1
    ev_t e;
    int k;
    k = kind_of(d1_done, d1_perr, d1_ferr, d1_ovr, d1_brk);
    if (k != 0) begin
      if (q1.size() == 0) chk_eq("d1_spurious", k, 0);
      else begin
        e = q1.pop_front();
        chk_eq("d1_event", k, e.kind);
        if (k == EV_DONE && e.kind == EV_DONE) chk_eq("d1_byte", int'(d1_byte), e.data);
      end
    end
  end

  always @(negedge clk) begin : mon2
    ev_t e;
    int k;
    k = kind_of(d2_done, d2_perr, d2_ferr, d2_ovr, d2_brk);
    if (k != 0) begin
      if (q2.size() == 0) chk_eq("d2_spurious", k, 0);
      else begin
        e = q2.pop_front();
        chk_eq("d2_event", k, e.kind);
        if (k == EV_DONE && e.kind == EV_DONE) chk_eq("d2_byte", int'(d2_byte), e.data);
      end
    end
  end

  task automatic drive_bit(input int ln, input logic b);
    r_Line[ln] = b;
    repeat (CPB) @(negedge clk);
  endtask

  // par: 0 none, 1 odd, 2 even; line is returned high afterwards
  task automatic send_frame(input int ln, input int data, input int nbits, input int par,
                            input int nstop, input bit flip_par, input bit stop_zero);
    logic p;
    logic pb;
    p = 1'b0;
    @(negedge clk);
    drive_bit(ln, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      drive_bit(ln, data[i]);
      p = p ^ data[i];
    end
    if (par != 0) begin
      pb = ((par == 1) ? ~p : p) ^ flip_par;
      drive_bit(ln, pb);
    end
    for (int i = 0; i < nstop; i++) drive_bit(ln, stop_zero ? 1'b0 : 1'b1);
    r_Line[ln] = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    repeat (n * CPB) @(negedge clk);
  endtask

  initial begin
    int d;
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 3; i++) begin
      r_Line[i]  = 1'b1;
      r_Ready[i] = 1'b1;
    end
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    chk_eq("rst_valid0", int'(d0_valid), 0);
    chk_eq("rst_byte0", int'(d0_byte), 0);
    chk_eq("rst_pulses0", int'({d0_done, d0_perr, d0_ferr, d0_ovr, d0_brk}), 0);
    chk_eq("rst_valid2", int'(d2_valid), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1 basic byte
    q0.push_back(mk(EV_DONE, 8'h55));
    send_frame(0, 8'h55, 8, 0, 1, 1'b0, 1'b0);
    idle_bits(2);
    chk_eq("n1_valid_consumed", int'(d0_valid), 0);

    // 8E1 good parity, then inverted parity
    q1.push_back(mk(EV_DONE, 8'hA5));
    send_frame(1, 8'hA5, 8, 2, 1, 1'b0, 1'b0);
    idle_bits(1);
    q1.push_back(mk(EV_PERR, 0));
    send_frame(1, 8'hA5, 8, 2, 1, 1'b1, 1'b0);
    idle_bits(2);
    chk_eq("perr_valid", int'(d1_valid), 0);

    // Overrun: consumer stalled
    r_Ready[1] = 1'b0;
    q1.push_back(mk(EV_DONE, 8'h11));
    send_frame(1, 8'h11, 8, 2, 1, 1'b0, 1'b0);
    q1.push_back(mk(EV_OVR, 0));
    send_frame(1, 8'h22, 8, 2, 1, 1'b0, 1'b0);
    idle_bits(1);
    chk_eq("ovr_byte_held", int'(d1_byte), 8'h11);
    chk_eq("ovr_valid_held", int'(d1_valid), 1);
    r_Ready[1] = 1'b1;
    @(negedge clk);
    r_Ready[1] = 1'b0;
    @(negedge clk);
    chk_eq("hs_valid_drop", int'(d1_valid), 0);
    r_Ready[1] = 1'b1;

    // Framing error, then recovery
    q0.push_back(mk(EV_FERR, 0));
    send_frame(0, 8'h3C, 8, 0, 1, 1'b0, 1'b1);
    idle_bits(1);
    q0.push_back(mk(EV_DONE, 8'hC3));
    send_frame(0, 8'hC3, 8, 0, 1, 1'b0, 1'b0);
    idle_bits(1);

    // Quarter-bit start glitch: nothing reported, next frame still received
    r_Line[0] = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    r_Line[0] = 1'b1;
    idle_bits(2);
    q0.push_back(mk(EV_DONE, 8'h5A));
    send_frame(0, 8'h5A, 8, 0, 1, 1'b0, 1'b0);
    idle_bits(1);

    // Async reset in the middle of the data bits
    @(negedge clk);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_eq("midrst_byte", int'(d0_byte), 0);
    chk_eq("midrst_valid", int'(d0_valid), 0);
    r_Line[0] = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    q0.push_back(mk(EV_DONE, 8'h7E));
    send_frame(0, 8'h7E, 8, 0, 1, 1'b0, 1'b0);
    idle_bits(1);

    // Line held low for two frame times
`ifdef UART_RX_BREAK_DETECT_EN
    q1.push_back(mk(EV_BRK, 0));
`else
    q1.push_back(mk(EV_FERR, 0));
`endif
    @(negedge clk);
    r_Line[1] = 1'b0;
    repeat (2 * 11 * CPB) @(negedge clk);
    r_Line[1] = 1'b1;
    idle_bits(2);
    q1.push_back(mk(EV_DONE, 8'h3A));
    send_frame(1, 8'h3A, 8, 2, 1, 1'b0, 1'b0);
    idle_bits(1);

    // 5O2 back-to-back random frames
    for (int i = 0; i < 16; i++) begin
      d = int'($urandom_range(0, 31));
      q2.push_back(mk(EV_DONE, d));
      send_frame(2, d, 5, 1, 2, 1'b0, 1'b0);
    end
    idle_bits(2);
    chk_eq("o2_valid_consumed", int'(d2_valid), 0);

    chk_eq("q0_drained", q0.size(), 0);
    chk_eq("q1_drained", q1.size(), 0);
    chk_eq("q2_drained", q2.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
